// File: rtl/mod_arb_pkg.sv
// -----------------------------------------------------------------------------
// mod_arb_pkg
// Shared definitions for the modulus arbiter slice.
//   CH0 / CH1  : channel identifiers, also used as the tag value
//   state_e    : arbiter FSM encoding (IDLE = 0, BUSY = 1)
//   clog2()    : bit width needed to index 'value' entries (minimum 1)
// -----------------------------------------------------------------------------
package mod_arb_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_tag_fifo.sv
// -----------------------------------------------------------------------------
// mod_tag_fifo
// 1-bit wide, DEPTH-deep synchronous FIFO holding the channel tag of every bin
// in flight through the modulus pipeline.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write push_tag_i (ignored when full and not popping)
//   push_tag_i    : tag to store
//   pop_i         : discard head entry (ignored when empty)
//   pop_tag_o     : head entry, meaningful only while !empty_o
//   empty_o       : no entries
//   full_o        : DEPTH entries
// A simultaneous push and pop is always accepted when the FIFO is non-empty,
// so the occupancy stays unchanged even at full.
// -----------------------------------------------------------------------------
module mod_tag_fifo
  import mod_arb_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic push_tag_i,
  input  logic pop_i,
  output logic pop_tag_o,
  output logic empty_o,
  output logic full_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign pop_tag_o = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; entries are only ever read behind
  // count_q, so resetting them would add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/modulus_arbiter.sv
// -----------------------------------------------------------------------------
// modulus_arbiter
// Shares one data_modulus (CORDIC magnitude, no backpressure) between two FFT
// output streams. Grants whole frames round-robin, tags every issued bin and
// steers returned magnitudes to per-channel outputs with bin index and frame
// length checks.
//   s0_* / s1_*     : per-channel FFT bin input (valid/ready, eop = last bin)
//   mod_*  (out)    : registered bin stream into data_modulus
//   mod_*  (in)     : modulus result stream from data_modulus
//   m0_* / m1_*     : per-channel magnitude, bin index, valid, eop
//   busy            : a frame is granted
//   len_err         : pulse, returned frame length differed from FFT_N
//   tag_err         : pulse, result with no tag, or tag dropped on a full FIFO
// Optional feature, macro MOD_ARB_WATCHDOG_EN: abort a granted frame after
// WD_CYCLES consecutive idle cycles and pulse the extra output wd_err.
// -----------------------------------------------------------------------------
module modulus_arbiter
  import mod_arb_pkg::*;
#(
  parameter int DW        = 16,
  parameter int FFT_N     = 1024,
  parameter int TAG_DEPTH = 32
`ifdef MOD_ARB_WATCHDOG_EN
  , parameter int WD_CYCLES = 4096
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DW-1:0]             s0_real,
  input  logic [DW-1:0]             s0_imag,
  input  logic                      s0_valid,
  input  logic                      s0_eop,
  output logic                      s0_ready,
  input  logic [DW-1:0]             s1_real,
  input  logic [DW-1:0]             s1_imag,
  input  logic                      s1_valid,
  input  logic                      s1_eop,
  output logic                      s1_ready,
  output logic [DW-1:0]             mod_real,
  output logic [DW-1:0]             mod_imag,
  output logic                      mod_valid,
  output logic                      mod_eop,
  input  logic [DW-1:0]             mod_modulus,
  input  logic                      mod_rvalid,
  input  logic                      mod_reop,
  output logic [DW-1:0]             m0_modulus,
  output logic [clog2(FFT_N)-1:0]   m0_bin,
  output logic                      m0_valid,
  output logic                      m0_eop,
  output logic [DW-1:0]             m1_modulus,
  output logic [clog2(FFT_N)-1:0]   m1_bin,
  output logic                      m1_valid,
  output logic                      m1_eop,
  output logic                      busy,
  output logic                      len_err,
  output logic                      tag_err
`ifdef MOD_ARB_WATCHDOG_EN
  , output logic                    wd_err
`endif
);

  localparam int BW = clog2(FFT_N);

  // ---------------------------------------------------------------- issue side
  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic            sel_valid, sel_eop, accept;
  logic [DW-1:0]   sel_real, sel_imag;
  logic [DW-1:0]   mod_real_q, mod_imag_q;
  logic            mod_valid_q, mod_eop_q, mod_tag_q;
  logic            wd_abort;

  assign sel_valid = (grant_q == CH1) ? s1_valid : s0_valid;
  assign sel_eop   = (grant_q == CH1) ? s1_eop   : s0_eop;
  assign sel_real  = (grant_q == CH1) ? s1_real  : s0_real;
  assign sel_imag  = (grant_q == CH1) ? s1_imag  : s0_imag;

  assign busy     = (state_q == BUSY);
  assign s0_ready = busy && (grant_q == CH0);
  assign s1_ready = busy && (grant_q == CH1);
  assign accept   = busy && sel_valid;

`ifdef MOD_ARB_WATCHDOG_EN
  localparam int WDW = clog2(WD_CYCLES + 1);
  logic [WDW-1:0] wd_cnt_q;
  logic           wd_err_q;

  // Fires on the WD_CYCLES-th consecutive cycle the granted channel is idle.
  assign wd_abort = busy && !sel_valid && (wd_cnt_q == WDW'(WD_CYCLES - 1));
  assign wd_err   = wd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_err_q <= wd_abort;
      if (!busy || sel_valid || wd_abort) wd_cnt_q <= '0;
      else                                wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign wd_abort = 1'b0;
`endif

  // NOTE: every combinational output gets its default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          // NOTE: blocking assignment here, so grant_d is read back below with
          // the value just chosen in this same evaluation.
          if (s0_valid && s1_valid) grant_d = ~last_grant_q;
          else                      grant_d = s1_valid ? CH1 : CH0;
          last_grant_d = grant_d;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if ((accept && sel_eop) || wd_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= CH0;
      last_grant_q <= CH1;
      mod_real_q   <= '0;
      mod_imag_q   <= '0;
      mod_valid_q  <= 1'b0;
      mod_eop_q    <= 1'b0;
      mod_tag_q    <= CH0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mod_valid_q  <= accept;
      mod_eop_q    <= accept && sel_eop;
      if (accept) begin
        mod_real_q <= sel_real;
        mod_imag_q <= sel_imag;
        mod_tag_q  <= grant_q;
      end
    end
  end

  assign mod_real  = mod_real_q;
  assign mod_imag  = mod_imag_q;
  assign mod_valid = mod_valid_q;
  assign mod_eop   = mod_eop_q;

  // ------------------------------------------------------------------ tag FIFO
  logic fifo_tag, fifo_empty, fifo_full;

  // The tag is pushed alongside the registered beat, which keeps tag order
  // identical to the order bins enter data_modulus.
  mod_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (mod_valid_q),
    .push_tag_i(mod_tag_q),
    .pop_i     (mod_rvalid),
    .pop_tag_o (fifo_tag),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // --------------------------------------------------------------- return side
  logic            ret_ok, ret_ch, at_last;
  logic [BW-1:0]   cur_bin, nxt_bin;
  logic            len_err_d, tag_err_d;
  logic [DW-1:0]   ret_mod_q [2];
  logic [BW-1:0]   ret_bin_q [2];
  logic [BW-1:0]   bin_cnt_q [2];
  logic [1:0]      ret_valid_q, ret_eop_q;
  logic            len_err_q, tag_err_q;

  assign ret_ok  = mod_rvalid && !fifo_empty;
  assign ret_ch  = fifo_tag;
  assign cur_bin = bin_cnt_q[ret_ch];
  assign at_last = (cur_bin == BW'(FFT_N - 1));
  // Counter restarts after an eop and also on a wrap without eop.
  assign nxt_bin = (mod_reop || at_last) ? '0 : cur_bin + 1'b1;
  // Length is wrong when eop and the last bin index disagree.
  assign len_err_d = ret_ok && (mod_reop ^ at_last);
  assign tag_err_d = (mod_rvalid && fifo_empty) ||
                     (mod_valid_q && fifo_full && !ret_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        ret_mod_q[c] <= '0;
        ret_bin_q[c] <= '0;
        bin_cnt_q[c] <= '0;
      end
      ret_valid_q <= '0;
      ret_eop_q   <= '0;
      len_err_q   <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      ret_valid_q <= '0;
      ret_eop_q   <= '0;
      len_err_q   <= len_err_d;
      tag_err_q   <= tag_err_d;
      if (ret_ok) begin
        ret_valid_q[ret_ch] <= 1'b1;
        ret_eop_q[ret_ch]   <= mod_reop;
        ret_mod_q[ret_ch]   <= mod_modulus;
        ret_bin_q[ret_ch]   <= cur_bin;
        bin_cnt_q[ret_ch]   <= nxt_bin;
      end
    end
  end

  assign m0_modulus = ret_mod_q[CH0];
  assign m0_bin     = ret_bin_q[CH0];
  assign m0_valid   = ret_valid_q[CH0];
  assign m0_eop     = ret_eop_q[CH0];
  assign m1_modulus = ret_mod_q[CH1];
  assign m1_bin     = ret_bin_q[CH1];
  assign m1_valid   = ret_valid_q[CH1];
  assign m1_eop     = ret_eop_q[CH1];
  assign len_err    = len_err_q;
  assign tag_err    = tag_err_q;

endmodule

// File: tb/tb_modulus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_modulus_arbiter
// Self-checking bench for modulus_arbiter with FFT_N = 8 and a 3-cycle
// behavioural data_modulus. Expected results are queued per channel when a beat
// is accepted and compared when the matching mN_valid appears.
// Define MOD_ARB_WATCHDOG_EN to also exercise the watchdog (WD_CYCLES = 16).
// -----------------------------------------------------------------------------
module tb_modulus_arbiter;
  import mod_arb_pkg::*;

  localparam int DW = 16;
  localparam int FFT_N = 8;
  localparam int BW = clog2(FFT_N);
  localparam int TMO = 200;

  logic clk, rst_n;
  logic [DW-1:0] s0_real, s0_imag, s1_real, s1_imag;
  logic s0_valid, s0_eop, s0_ready, s1_valid, s1_eop, s1_ready;
  logic [DW-1:0] mod_real, mod_imag, mod_modulus;
  logic mod_valid, mod_eop, mod_rvalid, mod_reop;
  logic [DW-1:0] m0_modulus, m1_modulus;
  logic [BW-1:0] m0_bin, m1_bin;
  logic m0_valid, m0_eop, m1_valid, m1_eop, busy, len_err, tag_err;
`ifdef MOD_ARB_WATCHDOG_EN
  logic wd_err;
`endif

  modulus_arbiter #(
    .DW(DW), .FFT_N(FFT_N), .TAG_DEPTH(32)
`ifdef MOD_ARB_WATCHDOG_EN
    , .WD_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_real(s0_real), .s0_imag(s0_imag), .s0_valid(s0_valid), .s0_eop(s0_eop), .s0_ready(s0_ready),
    .s1_real(s1_real), .s1_imag(s1_imag), .s1_valid(s1_valid), .s1_eop(s1_eop), .s1_ready(s1_ready),
    .mod_real(mod_real), .mod_imag(mod_imag), .mod_valid(mod_valid), .mod_eop(mod_eop),
    .mod_modulus(mod_modulus), .mod_rvalid(mod_rvalid), .mod_reop(mod_reop),
    .m0_modulus(m0_modulus), .m0_bin(m0_bin), .m0_valid(m0_valid), .m0_eop(m0_eop),
    .m1_modulus(m1_modulus), .m1_bin(m1_bin), .m1_valid(m1_valid), .m1_eop(m1_eop),
    .busy(busy), .len_err(len_err), .tag_err(tag_err)
`ifdef MOD_ARB_WATCHDOG_EN
    , .wd_err(wd_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ------------------------------------------------------------------ checking
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int isqrt(input int re, input int im);
    longint s, r, t;
    s = longint'(re) * re + longint'(im) * im;
    r = 0;
    for (int b = 16; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= s) r = t;
    end
    return int'(r);
  endfunction

  // ------------------------------------------------- 3-cycle data_modulus model
  logic [DW-1:0] p_m [3];
  logic [2:0]    p_v, p_e;
  logic          inj_rvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v <= '0;
      p_e <= '0;
      for (int i = 0; i < 3; i++) p_m[i] <= '0;
    end else begin
      p_v <= {p_v[1:0], mod_valid};
      p_e <= {p_e[1:0], mod_eop};
      p_m[0] <= DW'(isqrt($signed(mod_real), $signed(mod_imag)));
      p_m[1] <= p_m[0];
      p_m[2] <= p_m[1];
    end
  end

  assign mod_rvalid  = p_v[2] | inj_rvalid;
  assign mod_reop    = p_e[2];
  assign mod_modulus = p_m[2];

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int   modv;
    int   bin;
    logic eop;
    logic lerr;
  } exp_t;

  exp_t   q0[$], q1[$];
  int     eb[2];
  longint first_t[2], eop_t[2];
  int     max_fill, tag_err_seen;

  task automatic expect_result(input logic ch, input int modv, input logic eop);
    exp_t e;
    logic at_last;
    at_last = (eb[ch] == FFT_N - 1);
    e.modv = modv;
    e.bin  = eb[ch];
    e.eop  = eop;
    e.lerr = eop ^ at_last;
    eb[ch] = (eop || at_last) ? 0 : eb[ch] + 1;
    if (ch) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  // Issue-side latency: mod_valid must follow each accepted beat by one cycle.
  logic          acc_prev;
  logic [DW-1:0] re_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_prev <= 1'b0;
      re_prev  <= '0;
    end else begin
      acc_prev <= (s0_valid && s0_ready) || (s1_valid && s1_ready);
      re_prev  <= (s0_valid && s0_ready) ? s0_real : s1_real;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("mod_valid_latency", mod_valid, acc_prev);
      if (acc_prev) check("mod_real", mod_real, re_prev);
      if (m0_valid) begin
        if (q0.size() == 0) check("m0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("m0_modulus", m0_modulus, e.modv);
          check("m0_bin", m0_bin, e.bin);
          check("m0_eop", m0_eop, e.eop);
          check("m0_len_err", len_err, e.lerr);
        end
      end
      if (m1_valid) begin
        if (q1.size() == 0) check("m1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("m1_modulus", m1_modulus, e.modv);
          check("m1_bin", m1_bin, e.bin);
          check("m1_eop", m1_eop, e.eop);
          check("m1_len_err", len_err, e.lerr);
        end
      end
      if (!m0_valid && !m1_valid) check("len_err_idle", len_err, 0);
      if (int'(dut.u_tag_fifo.count_q) > max_fill) max_fill = int'(dut.u_tag_fifo.count_q);
      if (tag_err) tag_err_seen++;
    end
  end

  // ------------------------------------------------------------------- drivers
  task automatic send_beat(input logic ch, input int re, input int im,
                           input logic eop, input int modv);
    int   t;
    logic rdy;
    if (ch) begin
      s1_real = DW'(re); s1_imag = DW'(im); s1_eop = eop; s1_valid = 1'b1;
    end else begin
      s0_real = DW'(re); s0_imag = DW'(im); s0_eop = eop; s0_valid = 1'b1;
    end
    for (t = 0; t < TMO; t++) begin
      rdy = ch ? s1_ready : s0_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    if (t == TMO) check("accept_timeout", 0, 1);
    else begin
      expect_result(ch, modv, eop);
      if (first_t[ch] < 0) first_t[ch] = $time;
      if (eop) eop_t[ch] = $time;
    end
    @(negedge clk);
    if (ch) begin s1_valid = 1'b0; s1_eop = 1'b0; end
    else    begin s0_valid = 1'b0; s0_eop = 1'b0; end
  endtask

  task automatic send_frame(input logic ch, input int n, input logic eop_last, input int base);
    int re, im;
    for (int k = 0; k < n; k++) begin
      re = (k * 53 + base * 17) % 700 - 350;
      im = 200 - (k * 29 + base * 11) % 500;
      send_beat(ch, re, im, eop_last && (k == n - 1), isqrt(re, im));
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && (q0.size() + q1.size()) != 0; t++) @(negedge clk);
    check("drain_empty", q0.size() + q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_state();
    s0_valid = 0; s0_eop = 0; s1_valid = 0; s1_eop = 0;
    s0_real = '0; s0_imag = '0; s1_real = '0; s1_imag = '0;
    q0.delete(); q1.delete();
    eb = '{0, 0};
    first_t = '{-1, -1};
    eop_t = '{-1, -1};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s0_ready"}, s0_ready, 0);
    check({tag, "_s1_ready"}, s1_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mod_valid"}, mod_valid, 0);
    check({tag, "_mod_real"}, mod_real, 0);
    check({tag, "_m0_valid"}, m0_valid, 0);
    check({tag, "_m1_valid"}, m1_valid, 0);
    check({tag, "_len_err"}, len_err, 0);
    check({tag, "_tag_err"}, tag_err, 0);
  endtask

  // ---------------------------------------------------------------- test table
  typedef struct {
    int   re;
    int   im;
    logic eop;
    int   gap;
    int   exp_mod;
  } vec_t;

  initial begin
    vec_t tbl[8];
    inj_rvalid = 1'b0;
    max_fill = 0;
    tag_err_seen = 0;
    rst_n = 1'b0;
    clear_state();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single ch0 frame, alternating (100,100j) and (-300,-400j), with a gap.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{re: (i % 2) ? -300 : 100, im: (i % 2) ? -400 : 100,
                 eop: (i == 7), gap: (i == 3) ? 2 : 0, exp_mod: (i % 2) ? 500 : 141};
    for (int i = 0; i < 8; i++) begin
      repeat (tbl[i].gap) @(negedge clk);
      send_beat(CH0, tbl[i].re, tbl[i].im, tbl[i].eop, tbl[i].exp_mod);
    end
    drain();

    // Simultaneous requests after reset: ch0 first, ch1 after one bubble.
    do_reset();
    fork
      send_frame(CH0, 8, 1'b1, 1);
      send_frame(CH1, 8, 1'b1, 2);
    join
    check("tie_ch0_first", first_t[0] < first_t[1], 1);
    check("bubble_cycles", (first_t[1] - eop_t[0]) / 10, 2);
    drain();
    first_t = '{-1, -1};
    fork
      send_frame(CH0, 8, 1'b1, 3);
      send_frame(CH1, 8, 1'b1, 4);
    join
    check("alternate_ch0_again", first_t[0] < first_t[1], 1);
    drain();

    // Back-to-back frames: ch1 results return while ch0 issues.
    send_frame(CH1, 8, 1'b1, 5);
    send_frame(CH0, 8, 1'b1, 6);
    drain();
    check("fifo_max_fill_le4", max_fill <= 4, 1);

    // Short frame (eop on bin 5), then a full frame starting at bin 0.
    send_frame(CH0, 6, 1'b1, 7);
    send_frame(CH0, 8, 1'b1, 8);
    drain();

    // Result with no tag in flight: tag_err pulse, nothing steered out.
    inj_rvalid = 1'b1;
    @(negedge clk);
    inj_rvalid = 1'b0;
    check("tag_err_pulse", tag_err, 1);
    check("tag_err_no_m0", m0_valid, 0);
    check("tag_err_no_m1", m1_valid, 0);
    @(negedge clk);
    check("tag_err_one_cycle", tag_err, 0);

    // Reset mid-frame after 3 beats.
    for (int k = 0; k < 3; k++) send_beat(CH0, 10 * k + 3, 7, 1'b0, isqrt(10 * k + 3, 7));
    s0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    clear_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(CH1, 8, 1'b1, 9);
    check("post_reset_ch1_granted", first_t[1] >= 0, 1);
    drain();

`ifdef MOD_ARB_WATCHDOG_EN
    // ch0 stalls after 2 beats while ch1 is pending.
    do_reset();
    send_frame(CH0, 2, 1'b0, 10);
    fork
      send_frame(CH1, 8, 1'b1, 11);
      for (int k = 1; k <= 17; k++) begin
        @(negedge clk);
        if (k <= 16) check($sformatf("wd_err_cycle%0d", k), wd_err, k == 16);
        if (k == 16) check("wd_idle_busy", busy, 0);
        if (k == 17) check("wd_ch1_granted", s1_ready, 1);
      end
    join
    drain();
    send_frame(CH0, 8, 1'b1, 12);
    drain();
`endif

    check("tag_err_total", tag_err_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
